// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle for the multicycle CPU control FSM.
// mem_ready: the memory completes the current access in any cycle where it is 1;
// the controller holds mem_read/mem_write/iord/ir_write stable until that cycle.
interface multicycle_control_if;
  logic [31:0] instr;
  logic        beq_alu;
  logic        mem_ready;
  logic [3:0]  alu_sel;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_source;
  logic        reg_write;
  logic        mem_to_reg;
  logic        illegal;
  logic [2:0]  state;

  modport master (
    input  instr, beq_alu, mem_ready,
    output alu_sel, alu_src_a, alu_src_b, iord, mem_read, mem_write,
           ir_write, pc_write, pc_source, reg_write, mem_to_reg, illegal, state
  );

  modport slave (
    output instr, beq_alu, mem_ready,
    input  alu_sel, alu_src_a, alu_src_b, iord, mem_read, mem_write,
           ir_write, pc_write, pc_source, reg_write, mem_to_reg, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: fetch/decode/exec/mem/wb sequencing, ALU and mux
// selects, PC/IR/regfile/memory strobes and the branch decision.
module multicycle_control (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_control_if.master   bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;

  state_e      state_q, state_d;
  logic [1:0]  cls;
  logic [3:0]  func;
  logic        alu_func_ok;
  logic        is_nop, is_ralu, is_ialu, is_alu;
  logic        is_lw, is_sw, is_beq, is_bne, is_jmp, is_legal;
  logic        unused_instr_bits;

  logic [3:0]  alu_sel;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        iord, mem_read, mem_write, ir_write, pc_write;
  logic [1:0]  pc_source;
  logic        reg_write, mem_to_reg, illegal;

  assign cls               = bus.instr[31:30];
  assign func              = bus.instr[29:26];
  assign unused_instr_bits = ^bus.instr[25:0];

  always_comb begin
    case (func)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b0111, 4'b1001: alu_func_ok = 1'b1;
      default:                            alu_func_ok = 1'b0;
    endcase
  end

  assign is_nop   = (cls == 2'b00);
  assign is_ralu  = (cls == 2'b01) && alu_func_ok;
  assign is_ialu  = (cls == 2'b11) && alu_func_ok;
  assign is_alu   = is_ralu || is_ialu;
  assign is_lw    = (cls == 2'b10) && (func == 4'b0000);
  assign is_sw    = (cls == 2'b10) && (func == 4'b0001);
  assign is_beq   = (cls == 2'b10) && (func == 4'b0010);
  assign is_bne   = (cls == 2'b10) && (func == 4'b0011);
  assign is_jmp   = (cls == 2'b10) && (func == 4'b0100);
  assign is_legal = is_nop || is_alu || is_lw || is_sw || is_beq || is_bne || is_jmp;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    alu_sel    = 4'b0000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_sel   = ALU_ADD;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        // Branch target PC + (imm<<2) is formed here so EXEC can load it from ALUOut.
        alu_src_b = 2'b11;
        alu_sel   = ALU_ADD;
        if (is_nop) begin
          state_d = FETCH;
        end else if (!is_legal) begin
          illegal = 1'b1;
          state_d = FETCH;
        end else if (is_jmp) begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
          state_d   = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_src_a = 1'b1;
        state_d   = FETCH;
        if (is_alu) begin
          alu_sel   = func;
          alu_src_b = is_ialu ? 2'b10 : 2'b00;
          state_d   = WB;
        end else if (is_lw || is_sw) begin
          alu_src_b = 2'b10;
          alu_sel   = ALU_ADD;
          state_d   = MEM;
        end else if (is_beq || is_bne) begin
          alu_sel   = ALU_SUB;
          pc_source = 2'b01;
          pc_write  = is_beq ? bus.beq_alu : ~bus.beq_alu;
        end
      end
      MEM: begin
        iord      = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
        if (bus.mem_ready) state_d = is_lw ? WB : FETCH;
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_lw;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // Reset wins over everything so no write strobe escapes in the rst cycle.
    if (rst) begin
      alu_sel    = 4'b0000;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_source  = 2'b00;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign bus.alu_sel    = alu_sel;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.iord       = iord;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.pc_source  = pc_source;
  assign bus.reg_write  = reg_write;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.illegal    = illegal;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expected output vectors are queued
// with their stimulus, then replayed against the DUT and compared under a mask.
module tb_multicycle_control;
  typedef enum int {K_NOP, K_RALU, K_IALU, K_LW, K_SW, K_BEQ, K_BNE, K_JMP, K_ILL} kind_e;

  logic clk = 1'b0;
  logic rst;
  multicycle_control_if bus ();
  multicycle_control dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [19:0] exp_q[$];
  logic [19:0] msk_q[$];
  logic [34:0] stim_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [19:0] m_stb, m_sel, m_a, m_b, m_iord, m_pcs, m_m2r, m_rst, m_fetch, m_dec;
  logic [3:0]  alu_funcs [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h9};
  logic [3:0]  ill_funcs [8] = '{4'h6, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

  // {state, alu_sel, src_a, src_b, iord, mem_read, mem_write, ir_write, pc_write,
  //  pc_source, reg_write, mem_to_reg, illegal}
  function automatic logic [19:0] vec(input logic [2:0] st, input logic [3:0] sel,
                                      input logic a, input logic [1:0] b, input logic io,
                                      input logic mr, input logic mw, input logic irw,
                                      input logic pcw, input logic [1:0] pcs,
                                      input logic rw, input logic m2r, input logic ill);
    return {st, sel, a, b, io, mr, mw, irw, pcw, pcs, rw, m2r, ill};
  endfunction

  task automatic init_masks();
    m_stb   = vec(3'h7, 4'h0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
    m_sel   = vec(3'h0, 4'hF, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    m_a     = vec(3'h0, 4'h0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    m_b     = vec(3'h0, 4'h0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    m_iord  = vec(3'h0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    m_pcs   = vec(3'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    m_m2r   = vec(3'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    m_rst   = m_sel | (m_stb & ~vec(3'h7, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
    m_fetch = m_stb | m_sel | m_a | m_b | m_iord | m_pcs;
    m_dec   = m_stb | m_sel | m_a | m_b;
  endtask

  task automatic push(input logic r, input logic mr, input logic bq, input logic [31:0] ins,
                      input logic [19:0] e, input logic [19:0] m);
    stim_q.push_back({r, mr, bq, ins});
    exp_q.push_back(e);
    msk_q.push_back(m);
  endtask

  // Expected cycle-by-cycle behaviour of one whole instruction.
  task automatic push_instr(input kind_e k, input logic [31:0] ins, input int fwait,
                            input int mwait, input logic bq);
    logic [3:0] fn;
    logic       lw_op;
    logic       pcw;
    fn    = ins[29:26];
    lw_op = (k == K_LW);
    pcw   = (k == K_BEQ) ? bq : ~bq;
    for (int i = 0; i < fwait; i++)
      push(1'b0, 1'b0, bq, ins, vec(3'd0, 4'h2, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), m_fetch);
    push(1'b0, 1'b1, bq, ins, vec(3'd0, 4'h2, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0), m_fetch);
    case (k)
      K_JMP:   push(1'b0, 1'($urandom_range(0, 1)), bq, ins,
                    vec(3'd1, 4'h2, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0), m_dec | m_pcs);
      K_ILL:   push(1'b0, 1'($urandom_range(0, 1)), bq, ins,
                    vec(3'd1, 4'h2, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1), m_dec);
      default: push(1'b0, 1'($urandom_range(0, 1)), bq, ins,
                    vec(3'd1, 4'h2, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), m_dec);
    endcase
    case (k)
      K_RALU, K_IALU: begin
        push(1'b0, 1'($urandom_range(0, 1)), bq, ins,
             vec(3'd2, fn, 1'b1, (k == K_IALU) ? 2'b10 : 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), m_dec);
        push(1'b0, 1'($urandom_range(0, 1)), bq, ins,
             vec(3'd4, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0), m_stb | m_m2r);
      end
      K_LW, K_SW: begin
        push(1'b0, 1'($urandom_range(0, 1)), bq, ins,
             vec(3'd2, 4'h2, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), m_dec);
        for (int i = 0; i <= mwait; i++)
          push(1'b0, (i == mwait), bq, ins,
               vec(3'd3, 4'h0, 1'b0, 2'b00, 1'b1, lw_op, ~lw_op, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), m_stb | m_iord);
        if (lw_op)
          push(1'b0, 1'($urandom_range(0, 1)), bq, ins,
               vec(3'd4, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0), m_stb | m_m2r);
      end
      K_BEQ, K_BNE:
        push(1'b0, 1'($urandom_range(0, 1)), bq, ins,
             vec(3'd2, 4'h3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, pcw, 2'b01, 1'b0, 1'b0, 1'b0), m_dec | m_pcs);
      default: ;
    endcase
  endtask

  task automatic step(input logic [34:0] s, output logic [19:0] obs);
    rst           = s[34];
    bus.mem_ready = s[33];
    bus.beq_alu   = s[32];
    bus.instr     = s[31:0];
    @(negedge clk);
    obs = {bus.state, bus.alu_sel, bus.alu_src_a, bus.alu_src_b, bus.iord, bus.mem_read,
           bus.mem_write, bus.ir_write, bus.pc_write, bus.pc_source, bus.reg_write,
           bus.mem_to_reg, bus.illegal};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [19:0] obs, e, m;
    int cyc = 0;
    push(1'b1, 1'b1, 1'b0, 32'h0, 20'h0, m_rst);
    push(1'b1, 1'b0, 1'b1, 32'h8400_0000, 20'h0, m_rst);
    push_instr(K_NOP, 32'h0000_0000, 0, 0, 1'b0);
    while (exp_q.size() > 0) begin
      step(stim_q.pop_front(), obs);
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      n_checks++;
      if ((obs & m) !== (e & m)) begin
        n_fail++;
        $display("FAIL reset cyc%0d: got %h expected %h (mask %h)", cyc, obs & m, e & m, m);
      end else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_alu();
    logic [19:0] obs, e, m;
    int cyc = 0;
    push_instr(K_RALU, 32'h4800_0000, 0, 0, 1'b0);
    push_instr(K_IALU, 32'hC400_1234, 0, 0, 1'b1);
    push_instr(K_RALU, 32'h5C00_0000, 1, 0, 1'b0);
    push_instr(K_IALU, 32'hE400_0000, 0, 0, 1'b0);
    while (exp_q.size() > 0) begin
      step(stim_q.pop_front(), obs);
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      n_checks++;
      if ((obs & m) !== (e & m)) begin
        n_fail++;
        $display("FAIL alu cyc%0d: got %h expected %h (mask %h)", cyc, obs & m, e & m, m);
      end else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_branch();
    logic [19:0] obs, e, m;
    int cyc = 0;
    push_instr(K_BEQ, 32'h8800_0000, 0, 0, 1'b1);
    push_instr(K_BEQ, 32'h8800_0000, 0, 0, 1'b0);
    push_instr(K_BNE, 32'h8C00_0000, 0, 0, 1'b1);
    push_instr(K_BNE, 32'h8C00_0000, 0, 0, 1'b0);
    while (exp_q.size() > 0) begin
      step(stim_q.pop_front(), obs);
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      n_checks++;
      if ((obs & m) !== (e & m)) begin
        n_fail++;
        $display("FAIL branch cyc%0d: got %h expected %h (mask %h)", cyc, obs & m, e & m, m);
      end else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_mem_wait();
    logic [19:0] obs, e, m;
    int cyc = 0;
    push_instr(K_LW, 32'h8000_0000, 0, 3, 1'b0);
    push_instr(K_SW, 32'h8400_0000, 0, 0, 1'b0);
    push_instr(K_SW, 32'h8400_0000, 2, 1, 1'b1);
    push_instr(K_LW, 32'h8000_0000, 0, 0, 1'b1);
    while (exp_q.size() > 0) begin
      step(stim_q.pop_front(), obs);
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      n_checks++;
      if ((obs & m) !== (e & m)) begin
        n_fail++;
        $display("FAIL mem_wait cyc%0d: got %h expected %h (mask %h)", cyc, obs & m, e & m, m);
      end else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_illegal_jmp();
    logic [19:0] obs, e, m;
    int cyc = 0;
    push_instr(K_ILL, 32'h5800_0000, 0, 0, 1'b0);
    push_instr(K_ILL, 32'h9400_0000, 0, 0, 1'b0);
    push_instr(K_ILL, 32'hFC00_0000, 0, 0, 1'b1);
    push_instr(K_JMP, 32'h9000_0000, 0, 0, 1'b0);
    push_instr(K_NOP, 32'h3C00_0000, 0, 0, 1'b0);
    push_instr(K_JMP, 32'h9000_00FF, 1, 0, 1'b1);
    while (exp_q.size() > 0) begin
      step(stim_q.pop_front(), obs);
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      n_checks++;
      if ((obs & m) !== (e & m)) begin
        n_fail++;
        $display("FAIL illegal_jmp cyc%0d: got %h expected %h (mask %h)", cyc, obs & m, e & m, m);
      end else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] obs, e, m;
    int cyc = 0;
    // SW stalled in MEM with mem_write up, then reset for two cycles.
    push(1'b0, 1'b1, 1'b0, 32'h8400_0000,
         vec(3'd0, 4'h2, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0), m_fetch);
    push(1'b0, 1'b0, 1'b0, 32'h8400_0000,
         vec(3'd1, 4'h2, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), m_dec);
    push(1'b0, 1'b0, 1'b0, 32'h8400_0000,
         vec(3'd2, 4'h2, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), m_dec);
    push(1'b0, 1'b0, 1'b0, 32'h8400_0000,
         vec(3'd3, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), m_stb | m_iord);
    push(1'b1, 1'b0, 1'b0, 32'h8400_0000, 20'h0, m_rst);
    push(1'b1, 1'b1, 1'b0, 32'h8400_0000, 20'h0, m_rst);
    push_instr(K_RALU, 32'h4800_0000, 0, 0, 1'b0);
    while (exp_q.size() > 0) begin
      step(stim_q.pop_front(), obs);
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      n_checks++;
      if ((obs & m) !== (e & m)) begin
        n_fail++;
        $display("FAIL reset_mid cyc%0d: got %h expected %h (mask %h)", cyc, obs & m, e & m, m);
      end else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] obs, e, m;
    logic [31:0] ins;
    kind_e       k;
    int cyc = 0;
    for (int i = 0; i < 30; i++) begin
      k = kind_e'($urandom_range(0, 8));
      case (k)
        K_NOP:  ins = {2'b00, 4'($urandom_range(0, 15)), 26'($urandom)};
        K_RALU: ins = {2'b01, alu_funcs[$urandom_range(0, 7)], 26'($urandom)};
        K_IALU: ins = {2'b11, alu_funcs[$urandom_range(0, 7)], 26'($urandom)};
        K_LW:   ins = {2'b10, 4'h0, 26'($urandom)};
        K_SW:   ins = {2'b10, 4'h1, 26'($urandom)};
        K_BEQ:  ins = {2'b10, 4'h2, 26'($urandom)};
        K_BNE:  ins = {2'b10, 4'h3, 26'($urandom)};
        K_JMP:  ins = {2'b10, 4'h4, 26'($urandom)};
        default: ins = ($urandom_range(0, 1) == 0)
                       ? {2'b10, 4'($urandom_range(5, 15)), 26'($urandom)}
                       : {1'b0, 1'b1, ill_funcs[$urandom_range(0, 7)], 26'($urandom)};
      endcase
      push_instr(k, ins, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    while (exp_q.size() > 0) begin
      step(stim_q.pop_front(), obs);
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      n_checks++;
      if ((obs & m) !== (e & m)) begin
        n_fail++;
        $display("FAIL back_to_back cyc%0d: got %h expected %h (mask %h)", cyc, obs & m, e & m, m);
      end else n_pass++;
      cyc++;
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.mem_ready = 1'b0;
    bus.beq_alu   = 1'b0;
    bus.instr     = 32'h0;
    init_masks();
    test_reset();
    test_alu();
    test_branch();
    test_mem_wait();
    test_illegal_jmp();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
